// File: rtl/if_fetch_unit.sv
// IF-stage fetch controller: drives the instruction-memory request from the PC and fills the
// IF/ID register. Handles variable memory latency, ID back-pressure and branch flushes.
module if_fetch_unit #(
  parameter int unsigned PC_WIDTH    = 13,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PC_WIDTH-1:0]    i_pc_in,
  output logic [PC_WIDTH-1:0]    o_pc_next,
  output logic                   o_pc_write,
  output logic                   o_imem_req,
  output logic [PC_WIDTH-1:0]    o_imem_addr,
  input  logic                   i_imem_ack,
  input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
  input  logic                   i_id_stall,
  input  logic                   i_flush,
  output logic                   o_ifid_valid,
  output logic [INSTR_WIDTH-1:0] o_ifid_instr,
  output logic [PC_WIDTH-1:0]    o_ifid_pc
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic                   r_ifid_valid;
  logic [INSTR_WIDTH-1:0] r_ifid_instr;
  logic [PC_WIDTH-1:0]    r_ifid_pc;
  logic [INSTR_WIDTH-1:0] r_skid_instr;
  logic [PC_WIDTH-1:0]    r_skid_pc;
  logic [PC_WIDTH-1:0]    r_drain_addr;

  logic                   w_load;
  logic                   w_req;
  logic [PC_WIDTH-1:0]    w_addr;
  logic                   w_accept;
  logic                   w_new_valid;
  logic [INSTR_WIDTH-1:0] w_new_instr;
  logic [PC_WIDTH-1:0]    w_new_pc;
  logic                   w_skid_we;
  logic                   w_drain_we;

  assign w_load = ~r_ifid_valid | ~i_id_stall;

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_addr      = i_pc_in;
    w_accept    = 1'b0;
    w_new_valid = 1'b0;
    w_new_instr = i_imem_rdata;
    w_new_pc    = i_pc_in;
    w_skid_we   = 1'b0;
    w_drain_we  = 1'b0;
    case (r_state)
      StIdle: begin
        w_state_nxt = StFetch;
      end
      StFetch: begin
        w_req = 1'b1;
        if (i_imem_ack && !i_flush) begin
          w_accept = 1'b1;
          if (w_load) begin
            w_new_valid = 1'b1;
          end else begin
            w_skid_we   = 1'b1;
            w_state_nxt = StHold;
          end
        end else if (i_flush && !i_imem_ack) begin
          // Request still outstanding: keep presenting it until memory answers.
          w_drain_we  = 1'b1;
          w_state_nxt = StDrain;
        end
      end
      StHold: begin
        if (i_flush) begin
          w_state_nxt = StFetch;
        end else if (w_load) begin
          w_new_valid = 1'b1;
          w_new_instr = r_skid_instr;
          w_new_pc    = r_skid_pc;
          w_state_nxt = StFetch;
        end
      end
      StDrain: begin
        w_req  = 1'b1;
        w_addr = r_drain_addr;
        if (i_imem_ack) begin
          w_state_nxt = StFetch;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_drain_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_skid_we) begin
        r_skid_instr <= i_imem_rdata;
        r_skid_pc    <= i_pc_in;
      end
      if (w_drain_we) begin
        r_drain_addr <= i_pc_in;
      end
    end
  end

  // Flush wins over everything; a free slot with nothing new becomes a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= '0;
      r_ifid_pc    <= '0;
    end else if (i_flush) begin
      r_ifid_valid <= 1'b0;
    end else if (w_new_valid) begin
      r_ifid_valid <= 1'b1;
      r_ifid_instr <= w_new_instr;
      r_ifid_pc    <= w_new_pc;
    end else if (w_load) begin
      r_ifid_valid <= 1'b0;
    end
  end

  assign o_pc_next    = i_pc_in + PC_WIDTH'(1);
  assign o_pc_write   = (w_accept | i_flush) & rst_n;
  assign o_imem_req   = w_req;
  assign o_imem_addr  = w_addr;
  assign o_ifid_valid = r_ifid_valid;
  assign o_ifid_instr = r_ifid_instr;
  assign o_ifid_pc    = r_ifid_pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a transaction-level model (outstanding request, buffered
// words, IF/ID slot) is compared every cycle, plus hand-computed literal checks per scenario.
module tb_if_fetch_unit;

  localparam int unsigned PW = 13;
  localparam int unsigned IW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] pc = '0;
  logic [PW-1:0] pc_next;
  logic          pc_write;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [IW-1:0] imem_rdata;
  logic          id_stall = 1'b0;
  logic          flush = 1'b0;
  logic [PW-1:0] tgt = '0;
  logic          ifid_valid;
  logic [IW-1:0] ifid_instr;
  logic [PW-1:0] ifid_pc;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_pc_in      (pc),
    .o_pc_next    (pc_next),
    .o_pc_write   (pc_write),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_ack   (imem_ack),
    .i_imem_rdata (imem_rdata),
    .i_id_stall   (id_stall),
    .i_flush      (flush),
    .o_ifid_valid (ifid_valid),
    .o_ifid_instr (ifid_instr),
    .o_ifid_pc    (ifid_pc)
  );

  function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
    return {3'b101, a, 3'b010, a};
  endfunction

  assign imem_rdata = imem_ack ? mem_word(imem_addr) : '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Model state: bubble-after-reset flag, doomed outstanding request, buffered word, IF/ID.
  logic          m_started = 1'b0;
  logic          m_kill = 1'b0;
  logic [PW-1:0] m_kill_addr = '0;
  logic          m_buf = 1'b0;
  logic [IW-1:0] m_buf_instr = '0;
  logic [PW-1:0] m_buf_pc = '0;
  logic          m_v = 1'b0;
  logic [IW-1:0] m_instr = '0;
  logic [PW-1:0] m_pc = '0;

  function automatic logic exp_req();
    return m_started && !m_buf;
  endfunction

  function automatic logic [PW-1:0] exp_addr();
    return m_kill ? m_kill_addr : pc;
  endfunction

  function automatic logic exp_pcw();
    return rst_n && (flush || (exp_req() && !m_kill && imem_ack));
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic          req, acc, ld, pcw;
    logic          n_kill, n_buf, n_v;
    logic [PW-1:0] n_kill_addr, n_pc;
    logic [IW-1:0] n_instr;
    if (!rst_n) begin
      m_started <= 1'b0; m_kill <= 1'b0; m_kill_addr <= '0; m_buf <= 1'b0;
      m_buf_instr <= '0; m_buf_pc <= '0; m_v <= 1'b0; m_instr <= '0; m_pc <= '0;
      pc <= '0;
    end else begin
      req = exp_req();
      pcw = exp_pcw();
      acc = req && !m_kill && imem_ack && !flush;
      ld  = !m_v || !id_stall;
      n_kill = m_kill; n_kill_addr = m_kill_addr; n_buf = m_buf;
      n_v = m_v; n_instr = m_instr; n_pc = m_pc;
      if (m_kill && imem_ack) n_kill = 1'b0;
      if (flush) begin
        n_v = 1'b0;
        n_buf = 1'b0;
        if (req && !m_kill && !imem_ack) begin
          n_kill = 1'b1;
          n_kill_addr = pc;
        end
      end else if (ld) begin
        if (acc) begin
          n_v = 1'b1; n_instr = mem_word(pc); n_pc = pc;
        end else if (m_buf) begin
          n_v = 1'b1; n_instr = m_buf_instr; n_pc = m_buf_pc; n_buf = 1'b0;
        end else begin
          n_v = 1'b0;
        end
      end else if (acc) begin
        n_buf = 1'b1;
        m_buf_instr <= mem_word(pc);
        m_buf_pc <= pc;
      end
      m_started <= 1'b1;
      m_kill <= n_kill; m_kill_addr <= n_kill_addr; m_buf <= n_buf;
      m_v <= n_v; m_instr <= n_instr; m_pc <= n_pc;
      if (flush) pc <= tgt;
      else if (pcw) pc <= pc + PW'(1);
    end
  end

  always @(negedge clk) begin : compare
    logic [PW-1:0] inc;
    inc = pc + PW'(1);
    chk("req", {31'b0, imem_req}, {31'b0, exp_req()});
    if (exp_req()) chk("addr", {19'b0, imem_addr}, {19'b0, exp_addr()});
    chk("pc_write", {31'b0, pc_write}, {31'b0, exp_pcw()});
    chk("pc_next", {19'b0, pc_next}, {19'b0, inc});
    chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_v});
    if (m_v) begin
      chk("ifid_pc", {19'b0, ifid_pc}, {19'b0, m_pc});
      chk("ifid_instr", ifid_instr, m_instr);
    end
  end

  task automatic set_in(input logic a, input logic s, input logic f, input logic [PW-1:0] t);
    imem_ack = a; id_stall = s; flush = f; tgt = t;
    @(negedge clk);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int pulses;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_ifid_pc", {19'b0, ifid_pc}, 32'd0);
    chk("rst_ifid_instr", ifid_instr, 32'd0);
    rst_n = 1'b1;

    // Streaming from PC 0 with single-cycle ack.
    set_in(0, 0, 0, 0);
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    next_cyc();
    for (int k = 0; k < 4; k++) begin
      set_in(1, 0, 0, 0);
      chk("t2_addr", {19'b0, imem_addr}, k);
      chk("t2_pcw", {31'b0, pc_write}, 32'd1);
      if (k > 0) chk("t2_ifid_pc", {19'b0, ifid_pc}, k - 1);
      next_cyc();
    end
    set_in(0, 0, 0, 0);
    chk("t2_last_pc", {19'b0, ifid_pc}, 32'd3);
    chk("t2_last_instr", ifid_instr, 32'hA003_4003);
    chk("t2_next_addr", {19'b0, imem_addr}, 32'd4);
    next_cyc();

    // Redirect to 0x010, then three-cycle ack latency.
    set_in(0, 0, 1, 13'h010);
    chk("t3_flush_pcw", {31'b0, pc_write}, 32'd1);
    next_cyc();
    set_in(1, 0, 0, 0);
    chk("t3_drain_addr", {19'b0, imem_addr}, 32'd4);
    next_cyc();
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      set_in(k == 2, 0, 0, 0);
      chk("t3_addr_held", {19'b0, imem_addr}, 32'h010);
      pulses += int'(pc_write);
      next_cyc();
    end
    chk("t3_pulses", pulses, 1);
    set_in(0, 0, 0, 0);
    chk("t3_ifid_pc", {19'b0, ifid_pc}, 32'h010);
    chk("t3_ifid_valid", {31'b0, ifid_valid}, 32'd1);
    next_cyc();

    // Back-pressure: 0x005 lands in the skid buffer while ID stalls on 0x004.
    set_in(0, 0, 1, 13'h004);
    next_cyc();
    set_in(1, 0, 0, 0);
    next_cyc();
    set_in(1, 0, 0, 0);
    next_cyc();
    set_in(1, 1, 0, 0);
    chk("t4_addr", {19'b0, imem_addr}, 32'h005);
    chk("t4_ifid_pc_before", {19'b0, ifid_pc}, 32'h004);
    next_cyc();
    set_in(0, 1, 0, 0);
    chk("t4_hold_req", {31'b0, imem_req}, 32'd0);
    chk("t4_hold_ifid_pc", {19'b0, ifid_pc}, 32'h004);
    chk("t4_hold_valid", {31'b0, ifid_valid}, 32'd1);
    next_cyc();
    set_in(0, 0, 0, 0);
    chk("t4_release_req", {31'b0, imem_req}, 32'd0);
    next_cyc();
    set_in(0, 0, 0, 0);
    chk("t4_ifid_pc", {19'b0, ifid_pc}, 32'h005);
    chk("t4_ifid_instr", ifid_instr, mem_word(13'h005));
    chk("t4_req_resume", {31'b0, imem_req}, 32'd1);
    chk("t4_addr_resume", {19'b0, imem_addr}, 32'h006);
    next_cyc();

    // Flush with a request outstanding at 0x020, redirect to 0x100, ack two cycles later.
    set_in(0, 0, 1, 13'h020);
    next_cyc();
    set_in(1, 0, 0, 0);
    next_cyc();
    set_in(0, 0, 0, 0);
    chk("t5_addr", {19'b0, imem_addr}, 32'h020);
    next_cyc();
    set_in(0, 0, 1, 13'h100);
    chk("t5_flush_pcw", {31'b0, pc_write}, 32'd1);
    next_cyc();
    set_in(0, 0, 1, 13'h100);
    chk("t5_drain_addr", {19'b0, imem_addr}, 32'h020);
    chk("t5_drain_valid", {31'b0, ifid_valid}, 32'd0);
    next_cyc();
    set_in(1, 0, 0, 0);
    chk("t5_drain_addr2", {19'b0, imem_addr}, 32'h020);
    chk("t5_discard_pcw", {31'b0, pc_write}, 32'd0);
    next_cyc();
    set_in(0, 0, 0, 0);
    chk("t5_valid", {31'b0, ifid_valid}, 32'd0);
    chk("t5_new_addr", {19'b0, imem_addr}, 32'h100);
    chk("t5_new_req", {31'b0, imem_req}, 32'd1);
    next_cyc();

    // PC wrap at the top of the address space.
    set_in(0, 0, 1, 13'h1FFF);
    next_cyc();
    set_in(1, 0, 0, 0);
    next_cyc();
    set_in(1, 0, 0, 0);
    chk("t6_addr", {19'b0, imem_addr}, 32'h1FFF);
    chk("t6_pc_next", {19'b0, pc_next}, 32'h0000);
    next_cyc();
    set_in(0, 0, 0, 0);
    chk("t6_wrap_addr", {19'b0, imem_addr}, 32'h0000);
    chk("t6_ifid_pc", {19'b0, ifid_pc}, 32'h1FFF);
    next_cyc();

    // Asynchronous reset mid-fetch with a valid IF/ID entry.
    set_in(1, 0, 0, 0);
    next_cyc();
    imem_ack = 1'b0;
    #1;
    chk("t1_pre_valid", {31'b0, ifid_valid}, 32'd1);
    chk("t1_pre_req", {31'b0, imem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_req", {31'b0, imem_req}, 32'd0);
    chk("t1_valid", {31'b0, ifid_valid}, 32'd0);
    chk("t1_pcw", {31'b0, pc_write}, 32'd0);
    next_cyc();
    rst_n = 1'b1;
    set_in(0, 0, 0, 0);
    chk("t1_idle_req", {31'b0, imem_req}, 32'd0);
    next_cyc();
    set_in(0, 0, 0, 0);
    chk("t1_fetch_req", {31'b0, imem_req}, 32'd1);
    chk("t1_fetch_addr", {19'b0, imem_addr}, 32'd0);
    next_cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
